// File: rtl/div3_pkg.sv
// Shared types and helpers for the bit-serial divide-by-three controller.
// DIV3_RADIX4_EN selects two operand bits per shift step instead of one.
package div3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic [1:0] REM0 = 2'd0;
    localparam logic [1:0] REM1 = 2'd1;
    localparam logic [1:0] REM2 = 2'd2;

`ifdef DIV3_RADIX4_EN
    localparam int DIGIT_W = 2;
`else
    localparam int DIGIT_W = 1;
`endif

    // The unreachable remainder encoding 2'b11 is handled as if it were zero.
    function automatic logic [1:0] mod3_step(input logic [1:0] rem, input logic dbit);
        logic [1:0] result;
        case (rem)
            REM0:    result = dbit ? REM1 : REM0;
            REM1:    result = dbit ? REM0 : REM2;
            REM2:    result = dbit ? REM2 : REM1;
            default: result = dbit ? REM1 : REM0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/div3_serial_ctrl_if.sv
// Word-in / result-out valid-ready handshakes of the divide-by-three controller.
// The controller uses the slave modport; the producer/consumer side uses master.
interface div3_serial_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_rem;
    logic             out_div3;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_rem, out_div3
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_rem, out_div3
    );

endinterface

// File: rtl/div3_rem_step.sv
// Combinational next-remainder logic for one shift step.
// DIV3_RADIX4_EN: two-bit digit, rem_next = (rem + pair) mod 3; otherwise one bit.
module div3_rem_step
    import div3_pkg::*;
(
    input  logic [1:0]         rem,
    input  logic [DIGIT_W-1:0] digit,
    output logic [1:0]         rem_next
);

`ifdef DIV3_RADIX4_EN
    logic [1:0] rem_norm;
    logic [2:0] sum;

    // Since 4 == 1 (mod 3), the shifted-in remainder simply adds to the pair.
    always_comb begin
        rem_norm = (rem == 2'b11) ? REM0 : rem;
        sum      = {1'b0, rem_norm} + {1'b0, digit};
        case (sum)
            3'd0, 3'd3: rem_next = REM0;
            3'd1, 3'd4: rem_next = REM1;
            3'd2, 3'd5: rem_next = REM2;
            default:    rem_next = REM0;
        endcase
    end
`else
    assign rem_next = mod3_step(rem, digit[0]);
`endif

endmodule

// File: rtl/div3_serial_ctrl.sv
// Bit-serial divisibility-by-three controller: FSM, counter, shift register, result registers.
// Optional feature macro: DIV3_RADIX4_EN (two bits per cycle, WIDTH must be even).
module div3_serial_ctrl
    import div3_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               RESET_N,
    div3_serial_ctrl_if.slave  bus,
    output logic               busy
);

`ifdef DIV3_RADIX4_EN
    localparam int STEPS = WIDTH / 2;
`else
    localparam int STEPS = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] STEPS_C = CW'(STEPS);
    localparam logic [CW-1:0] ONE     = CW'(1);

    generate
        if (WIDTH < 2) begin : g_width_chk
            $error("div3_serial_ctrl: WIDTH must be at least 2");
        end
`ifdef DIV3_RADIX4_EN
        if (WIDTH % 2 != 0) begin : g_even_chk
            $error("div3_serial_ctrl: WIDTH must be even for radix-4 operation");
        end
`endif
    endgenerate

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   shift_q;
    logic [1:0]         rem_q;
    logic [1:0]         rem_next;
    logic [CW-1:0]      cnt_q;
    logic               out_valid_q;
    logic [1:0]         out_rem_q;
    logic               out_div3_q;
    logic               in_ready_d;
    logic [DIGIT_W-1:0] digit;
    logic               last_step;

    assign digit     = shift_q[WIDTH-1 -: DIGIT_W];
    assign last_step = (cnt_q <= ONE);

    div3_rem_step u_rem_step (
        .rem      (rem_q),
        .digit    (digit),
        .rem_next (rem_next)
    );

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = SHIFT;
            SHIFT:   if (last_step)     state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // in_ready and busy depend on the state register alone.
    always_comb begin
        in_ready_d = 1'b0;
        busy       = 1'b0;
        case (state_q)
            IDLE:    in_ready_d = 1'b1;
            SHIFT:   busy       = 1'b1;
            DONE:    busy       = 1'b1;
            default: in_ready_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            shift_q     <= '0;
            rem_q       <= REM0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_rem_q   <= REM0;
            out_div3_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        shift_q <= bus.in_data;
                        rem_q   <= REM0;
                        cnt_q   <= STEPS_C;
                    end
                end
                SHIFT: begin
                    rem_q   <= rem_next;
                    shift_q <= shift_q << DIGIT_W;
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - ONE;
                    end
                    // The result is registered on the edge that consumes the last digit.
                    if (last_step) begin
                        out_valid_q <= 1'b1;
                        out_rem_q   <= rem_next;
                        out_div3_q  <= (rem_next == REM0);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_d;
    assign bus.out_valid = out_valid_q;
    assign bus.out_rem   = out_rem_q;
    assign bus.out_div3  = out_div3_q;

endmodule

// File: tb/tb_div3_serial_ctrl.sv
// Self-checking bench for div3_serial_ctrl with WIDTH=8 and hand-computed expectations.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_div3_serial_ctrl;

`ifdef DIV3_RADIX4_EN
    localparam int STEPS = 4;
`else
    localparam int STEPS = 8;
`endif

    logic clk;
    logic RESET_N;
    logic busy;
    int   total;
    int   bad;

    div3_serial_ctrl_if #(.WIDTH(8)) bus ();

    div3_serial_ctrl #(.WIDTH(8)) dut (
        .clk     (clk),
        .RESET_N (RESET_N),
        .bus     (bus),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, then presents the word for exactly one accept edge.
    task automatic applyStimulus(input logic [7:0] value);
        int n;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!bus.in_ready) checkOutput("in_ready_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = value;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic waitValid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        if (!bus.out_valid) checkOutput("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic collectResult(input int hold, output logic [1:0] rem, output logic div, output int lat);
        waitValid(lat);
        rem = bus.out_rem;
        div = bus.out_div3;
        repeat (hold) tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] dir_val [4];
        logic [1:0] dir_rem [4];
        logic       dir_div [4];
        logic [7:0] b2b_val [3];
        int         acc_t [3];
        logic [1:0] res [3];
        logic [1:0] rem;
        logic       div;
        int         lat;
        int         cyc;
        int         idx;
        int         nres;
        logic       prev_ready;

        dir_val = '{8'h00, 8'hFF, 8'h64, 8'h05};
        dir_rem = '{2'd0, 2'd0, 2'd1, 2'd2};
        dir_div = '{1'b1, 1'b1, 1'b0, 1'b0};
        b2b_val = '{8'h03, 8'h04, 8'h08};
        acc_t   = '{0, 0, 0};
        res     = '{2'd3, 2'd3, 2'd3};

        total         = 0;
        bad           = 0;
        RESET_N       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) tick();
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_rem", 32'(bus.out_rem), 32'd0);
        checkOutput("rst_out_div3", 32'(bus.out_div3), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        RESET_N = 1'b1;
        tick();
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed words with latency check
        for (int i = 0; i < 4; i++) begin
            applyStimulus(dir_val[i]);
            checkOutput($sformatf("dir_busy_%0h", dir_val[i]), 32'(busy), 32'd1);
            collectResult(0, rem, div, lat);
            checkOutput($sformatf("dir_rem_%0h", dir_val[i]), 32'(rem), 32'(dir_rem[i]));
            checkOutput($sformatf("dir_div_%0h", dir_val[i]), 32'(div), 32'(dir_div[i]));
            checkOutput($sformatf("dir_lat_%0h", dir_val[i]), 32'(lat), 32'(STEPS));
            checkOutput($sformatf("dir_released_%0h", dir_val[i]), 32'(bus.out_valid), 32'd0);
        end

        // Backpressure: result held 10 cycles while in_valid pulses
        applyStimulus(8'h64);
        waitValid(lat);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.in_data  = 8'h05;
            tick();
            checkOutput("bp_out_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("bp_out_rem", 32'(bus.out_rem), 32'd1);
            checkOutput("bp_out_div3", 32'(bus.out_div3), 32'd0);
            checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        checkOutput("bp_xfer_valid_low", 32'(bus.out_valid), 32'd0);
        checkOutput("bp_xfer_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        checkOutput("bp_accept_after", 32'(busy), 32'd1);
        collectResult(0, rem, div, lat);
        checkOutput("bp_next_rem", 32'(rem), 32'd2);
        checkOutput("bp_next_lat", 32'(lat), 32'(STEPS));

        // Reset in the middle of SHIFT
        applyStimulus(8'h64);
        repeat (3) tick();
        RESET_N = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midrst_out_rem", 32'(bus.out_rem), 32'd0);
        checkOutput("midrst_out_div3", 32'(bus.out_div3), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        tick();
        RESET_N = 1'b1;
        #1;
        checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        applyStimulus(8'h05);
        collectResult(0, rem, div, lat);
        checkOutput("midrst_next_rem", 32'(rem), 32'd2);
        checkOutput("midrst_next_div", 32'(div), 32'd0);
        checkOutput("midrst_next_lat", 32'(lat), 32'(STEPS));

        // Back-to-back words with in_valid and out_ready held high
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = b2b_val[0];
        idx  = 0;
        nres = 0;
        cyc  = 0;
        while (nres < 3 && cyc < 200) begin
            prev_ready = bus.in_ready;
            tick();
            cyc++;
            if (prev_ready && bus.in_valid) begin
                acc_t[idx] = cyc;
                idx++;
                if (idx < 3) bus.in_data = b2b_val[idx];
                else bus.in_valid = 1'b0;
            end
            if (bus.out_valid && nres < 3) begin
                res[nres] = bus.out_rem;
                nres++;
            end
        end
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        checkOutput("b2b_count", 32'(nres), 32'd3);
        checkOutput("b2b_rem_03", 32'(res[0]), 32'd0);
        checkOutput("b2b_rem_04", 32'(res[1]), 32'd1);
        checkOutput("b2b_rem_08", 32'(res[2]), 32'd2);
        checkOutput("b2b_gap_1", 32'(acc_t[1] - acc_t[0]), 32'(STEPS + 2));
        checkOutput("b2b_gap_2", 32'(acc_t[2] - acc_t[1]), 32'(STEPS + 2));

        // Every 8-bit value with random idle and backpressure gaps
        for (int v = 0; v < 256; v++) begin
            repeat ($urandom_range(0, 2)) tick();
            applyStimulus(8'(v));
            collectResult(int'($urandom_range(0, 3)), rem, div, lat);
            checkOutput($sformatf("exh_rem_%0d", v), 32'(rem), 32'(v % 3));
            checkOutput($sformatf("exh_div_%0d", v), 32'(div), 32'(v % 3 == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
